alu_mac_sequencer: RTL and testbench

//  Drives the 16-bit ALU (ALU_IN1/ALU_IN2/CTRL in, ALU_OUT/z out) to compute a dot product.

---
 rtl/alu_mac_sequencer_pkg.sv | 32 +++
 rtl/alu_mac_sequencer.sv | 133 +++++++++++++
 tb/tb_alu_mac_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_mac_sequencer_pkg.sv
// Shared definitions for the ALU-driven dot-product sequencer: ALU opcodes,
// the ALU width and the sequencer state encoding.
package alu_mac_sequencer_pkg;

  localparam int ALU_W = 16;

  typedef logic [2:0] alu_op_t;

  localparam alu_op_t ALU_ADD   = 3'b000;
  localparam alu_op_t ALU_MUL   = 3'b001;
  localparam alu_op_t ALU_SUB   = 3'b010;
  localparam alu_op_t ALU_M8Z   = 3'b011;
  localparam alu_op_t ALU_MOV13 = 3'b100;
  localparam alu_op_t ALU_MOV02 = 3'b101;
  localparam alu_op_t ALU_ZERO  = 3'b110;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_FETCH,
    S_MUL,
    S_ACC,
    S_DEC,
    S_DONE
  } state_t;

  // Only ADD, MUL, SUB and ZERO are ever put on the ALU by this block.
  function automatic logic op_is_issued(alu_op_t op);
    return (op == ALU_ADD) || (op == ALU_MUL) || (op == ALU_SUB) || (op == ALU_ZERO);
  endfunction

endpackage

// File: rtl/alu_mac_sequencer.sv
// Dot-product sequencer: fetches operand pairs over req/valid and computes
// sum(A*B) mod 2^WIDTH by driving an external combinational ALU.
module alu_mac_sequencer
  import alu_mac_sequencer_pkg::*;
#(
  parameter int WIDTH = ALU_W,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] LEN,
  output logic             op_req,
  input  logic             op_valid,
  input  logic [WIDTH-1:0] OPA_IN,
  input  logic [WIDTH-1:0] OPB_IN,
  output logic [WIDTH-1:0] ALU_IN1,
  output logic [WIDTH-1:0] ALU_IN2,
  output logic [2:0]       CTRL,
  input  logic [WIDTH-1:0] ALU_OUT,
  input  logic             z,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] RESULT
);

  state_t state_reg, state_next;

  logic [WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0] prod_reg;
  logic [LEN_W-1:0] cnt_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] result_reg;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; the loop exit comes from the ALU z flag on the decrement
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (start) state_next = S_CLR;
      S_CLR:   state_next = (cnt_reg == '0) ? S_DONE : S_FETCH;
      S_FETCH: if (op_valid) state_next = S_MUL;
      S_MUL:   state_next = S_ACC;
      S_ACC:   state_next = S_DEC;
      S_DEC:   state_next = z ? S_DONE : S_FETCH;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath registers; every arithmetic result is taken from ALU_OUT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg    <= '0;
      prod_reg   <= '0;
      cnt_reg    <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      result_reg <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) cnt_reg <= LEN;
        end
        S_CLR: begin
          acc_reg <= ALU_OUT;
          if (cnt_reg == '0) result_reg <= '0;
        end
        S_FETCH: begin
          if (op_valid) begin
            a_reg <= OPA_IN;
            b_reg <= OPB_IN;
          end
        end
        S_MUL: begin
          prod_reg <= ALU_OUT;
        end
        S_ACC: begin
          acc_reg <= ALU_OUT;
        end
        S_DEC: begin
          cnt_reg <= LEN_W'(ALU_OUT);
          if (z) result_reg <= acc_reg;
        end
        default: begin
        end
      endcase
    end
  end

  // Output logic: ALU drive and handshake/status flags
  always_comb begin
    ALU_IN1 = '0;
    ALU_IN2 = '0;
    CTRL    = ALU_ZERO;
    op_req  = 1'b0;
    done    = 1'b0;
    busy    = (state_reg != S_IDLE);
    case (state_reg)
      S_FETCH: op_req = 1'b1;
      S_MUL: begin
        ALU_IN1 = a_reg;
        ALU_IN2 = b_reg;
        CTRL    = ALU_MUL;
      end
      S_ACC: begin
        ALU_IN1 = acc_reg;
        ALU_IN2 = prod_reg;
        CTRL    = ALU_ADD;
      end
      S_DEC: begin
        ALU_IN1 = WIDTH'(cnt_reg);
        ALU_IN2 = WIDTH'(1);
        CTRL    = ALU_SUB;
      end
      S_DONE: done = 1'b1;
      default: begin
      end
    endcase
  end

  assign RESULT = result_reg;

endmodule

// File: tb/tb_alu_mac_sequencer.sv
// Bench for alu_mac_sequencer: behavioural 16-bit ALU beside the DUT, randomized
// operands and stalls, expected results from a plain dot-product model.
module tb_alu_mac_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] LEN;
  logic        op_req;
  logic        op_valid;
  logic [15:0] OPA_IN;
  logic [15:0] OPB_IN;
  logic [15:0] ALU_IN1;
  logic [15:0] ALU_IN2;
  logic [2:0]  CTRL;
  logic [15:0] ALU_OUT;
  logic        z;
  logic        busy;
  logic        done;
  logic [15:0] RESULT;

  int vectors;
  int miscompares;

  logic [15:0] a_mem [64];
  logic [15:0] b_mem [64];
  int          stall_mem [64];
  logic [15:0] model_result;

  alu_mac_sequencer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .LEN      (LEN),
    .op_req   (op_req),
    .op_valid (op_valid),
    .OPA_IN   (OPA_IN),
    .OPB_IN   (OPB_IN),
    .ALU_IN1  (ALU_IN1),
    .ALU_IN2  (ALU_IN2),
    .CTRL     (CTRL),
    .ALU_OUT  (ALU_OUT),
    .z        (z),
    .busy     (busy),
    .done     (done),
    .RESULT   (RESULT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural combinational ALU
  always_comb begin
    case (CTRL)
      3'b000:  ALU_OUT = ALU_IN1 + ALU_IN2;
      3'b001:  ALU_OUT = 16'(ALU_IN1 * ALU_IN2);
      3'b010:  ALU_OUT = ALU_IN1 - ALU_IN2;
      default: ALU_OUT = 16'h0000;
    endcase
    z = (ALU_OUT == 16'h0000);
  end

  // The sequencer may only ever issue ADD, MUL, SUB or ZERO
  always @(negedge clk) begin
    if (rst_n) begin
      vectors++;
      if (!(CTRL == 3'b000 || CTRL == 3'b001 || CTRL == 3'b010 || CTRL == 3'b110)) begin
        miscompares++;
        $display("FAIL illegal_opcode: CTRL=%03b, required one of 000/001/010/110", CTRL);
      end
    end
  end

  // One dot product: a_mem/b_mem/stall_mem hold the pairs and per-pair FETCH stalls.
  // pulse_cyc > 0 re-asserts start in that (busy) cycle, which must be ignored.
  task automatic run_dot(input int len, input int pulse_cyc, input string tag);
    int          cyc, pair, stall_left, exp_done, stall_total, done_cnt, done_at;
    logic [31:0] sum;
    logic [15:0] exp_res, exp_now;
    sum = 0;
    stall_total = 0;
    for (int i = 0; i < len; i++) begin
      sum += 32'(a_mem[i]) * 32'(b_mem[i]);
      stall_total += stall_mem[i];
    end
    exp_res  = sum[15:0];
    exp_done = 2 + 4 * len + stall_total;

    @(negedge clk);
    start    = 1'b1;
    LEN      = 16'(len);
    op_valid = 1'($urandom);
    cyc      = 0;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s idle_busy: busy=%0b, required 0", tag, busy);
    end
    pair = 0;
    stall_left = stall_mem[0];
    done_cnt = 0;
    done_at = -1;
    while (cyc < exp_done + 3) begin
      @(negedge clk);
      cyc++;
      vectors++;
      if (busy !== (cyc <= exp_done)) begin
        miscompares++;
        $display("FAIL %s busy: cycle %0d busy=%0b, required %0b", tag, cyc, busy, cyc <= exp_done);
      end
      if (done) begin
        done_cnt++;
        done_at = cyc;
      end
      exp_now = (cyc < exp_done) ? model_result : exp_res;
      vectors++;
      if (RESULT !== exp_now) begin
        miscompares++;
        $display("FAIL %s result: cycle %0d RESULT=%04h, required %04h", tag, cyc, RESULT, exp_now);
      end
      if (op_req) begin
        vectors++;
        if (len == 0 || pair >= len || CTRL !== 3'b110 || ALU_IN1 !== 16'h0 || ALU_IN2 !== 16'h0) begin
          miscompares++;
          $display("FAIL %s fetch_drive: cycle %0d pair %0d CTRL=%03b IN1=%04h IN2=%04h, required 110/0000/0000 within %0d pairs",
                   tag, cyc, pair, CTRL, ALU_IN1, ALU_IN2, len);
        end
      end
      // Drive inputs for the next rising edge
      start = (cyc == pulse_cyc);
      LEN   = 16'($urandom_range(1, 9));
      if (op_req && pair < len) begin
        if (stall_left > 0) begin
          op_valid = 1'b0;
          OPA_IN = 16'($urandom);
          OPB_IN = 16'($urandom);
          stall_left--;
        end else begin
          op_valid = 1'b1;
          OPA_IN = a_mem[pair];
          OPB_IN = b_mem[pair];
          pair++;
          stall_left = stall_mem[pair];
        end
      end else begin
        op_valid = 1'($urandom);
        OPA_IN = 16'($urandom);
        OPB_IN = 16'($urandom);
      end
    end
    start = 1'b0;
    vectors++;
    if (done_cnt !== 1 || done_at !== exp_done) begin
      miscompares++;
      $display("FAIL %s done_timing: %0d pulses, last in cycle %0d, required 1 pulse in cycle %0d",
               tag, done_cnt, done_at, exp_done);
    end
    vectors++;
    if (pair !== len) begin
      miscompares++;
      $display("FAIL %s pairs: %0d pairs transferred, required %0d", tag, pair, len);
    end
    model_result = exp_res;
    $display("%s: LEN=%0d stalls=%0d RESULT=%04h expected %04h done_cycle=%0d expected %0d",
             tag, len, stall_total, RESULT, exp_res, done_at, exp_done);
  endtask

  task automatic load_test2(input int stall);
    for (int i = 0; i < 3; i++) begin
      a_mem[i] = 16'(i + 1);
      b_mem[i] = 16'(i + 4);
      stall_mem[i] = stall;
    end
    stall_mem[3] = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    LEN = 16'h0;
    op_valid = 1'b0;
    OPA_IN = 16'h0;
    OPB_IN = 16'h0;
    repeat (3) @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || op_req !== 1'b0 || RESULT !== 16'h0 ||
        CTRL !== 3'b110 || ALU_IN1 !== 16'h0 || ALU_IN2 !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_state: busy=%0b done=%0b op_req=%0b RESULT=%04h CTRL=%03b IN1=%04h IN2=%04h, required 0/0/0/0000/110/0000/0000",
               busy, done, op_req, RESULT, CTRL, ALU_IN1, ALU_IN2);
    end
    rst_n = 1'b1;
    model_result = 16'h0;
    $display("reset: RESULT=%04h CTRL=%03b busy=%0b", RESULT, CTRL, busy);
  endtask

  task automatic test_basic();
    load_test2(0);
    run_dot(3, 0, "basic_len3");
  endtask

  task automatic test_len_zero();
    stall_mem[0] = 0;
    run_dot(0, 0, "len_zero");
  endtask

  task automatic test_truncation();
    a_mem[0] = 16'h0100; b_mem[0] = 16'h0100; stall_mem[0] = 0;
    a_mem[1] = 16'h0100; b_mem[1] = 16'h0001; stall_mem[1] = 0;
    stall_mem[2] = 0;
    run_dot(2, 0, "truncation");
  endtask

  task automatic test_stall();
    load_test2(4);
    run_dot(3, 0, "stall");
  endtask

  task automatic test_restart_ignored();
    load_test2(1);
    run_dot(3, 5, "start_while_busy");
  endtask

  task automatic test_reset_mid_run();
    int  budget;
    logic seen;
    @(negedge clk);
    start = 1'b1;
    LEN = 16'd3;
    op_valid = 1'b1;
    OPA_IN = 16'h1234;
    OPB_IN = 16'h0055;
    seen = 1'b0;
    budget = 0;
    while (!seen && budget < 40) begin
      @(negedge clk);
      start = 1'b0;
      budget++;
      seen = (CTRL == 3'b000) && busy;
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL reach_acc: no ADD cycle within %0d cycles, required one", budget);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || op_req !== 1'b0 || RESULT !== 16'h0 || CTRL !== 3'b110) begin
      miscompares++;
      $display("FAIL mid_run_reset: busy=%0b done=%0b op_req=%0b RESULT=%04h CTRL=%03b, required 0/0/0/0000/110",
               busy, done, op_req, RESULT, CTRL);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_result = 16'h0;
    $display("mid_run_reset: busy=%0b RESULT=%04h", busy, RESULT);
    load_test2(0);
    run_dot(3, 0, "after_reset");
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      int len, pulse;
      len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++) begin
        a_mem[i] = 16'($urandom);
        b_mem[i] = 16'($urandom);
        stall_mem[i] = $urandom_range(0, 3);
      end
      stall_mem[len] = 0;
      pulse = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 2 + 4 * len) : 0;
      run_dot(len, pulse, $sformatf("random%0d", r));
    end
  endtask

  task automatic test_back_to_back();
    a_mem[0] = 16'hFFFF; b_mem[0] = 16'hFFFF; stall_mem[0] = 0;
    stall_mem[1] = 0;
    run_dot(1, 0, "b2b_first");
    a_mem[0] = 16'h0003; b_mem[0] = 16'h0007; stall_mem[0] = 2;
    run_dot(1, 0, "b2b_second");
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_basic();
    test_len_zero();
    test_truncation();
    test_stall();
    test_restart_ignored();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
